jedro_1_irq_ctrl: RTL
=====================

Name: jedro_1_irq_ctrl

Overview:
Machine-mode interrupt controller for the jedro_1 core. It synchronises the three interrupt lines, masks them with mstatus.MIE and the mie enable bits, and picks one winner by fixed priority. It waits for a safe instruction boundary, then issues a single registered trap request with its mcause value to the CSR/trap logic, and holds it until that logic acknowledges.

Parameters:
DATA_WIDTH, 32, width of irq_cause_o (mcause format).
SYNC_STAGES, 2, flip-flop stages per interrupt line (legal 1..3).
HOLDOFF_CYCLES, 2, idle cycles after an ack before re-arbitration (legal 0..15); covers the mstatus.MIE clear propagating.

Ports:
clk_i  in  1  core clock.
rstn_i  in  1  reset; asynchronous, active-low.
sw_irq_i  in  1  raw software interrupt, level.
timer_irq_i  in  1  raw timer interrupt, level.
ext_irq_i  in  1  raw external interrupt, level.
mstatus_mie_i  in  1  global machine interrupt enable from CSR.
mie_msie_i  in  1  software interrupt enable.
mie_mtie_i  in  1  timer interrupt enable.
mie_meie_i  in  1  external interrupt enable.
instr_boundary_i  in  1  decoder at an instruction boundary; safe to redirect.
exc_pending_i  in  1  synchronous exception being raised this cycle.
mret_i  in  1  mret executing this cycle.
irq_ack_i  in  1  CSR/trap logic has taken the interrupt trap.
irq_req_o  out  1  interrupt trap request, registered.
irq_cause_o  out  DATA_WIDTH  mcause value for the request, registered; bit DATA_WIDTH-1 = 1.
busy_o  out  1  high in ARM, REQ or HOLDOFF.

Behaviour:
- Reset (async assert, rstn_i=0):
  - synchroniser flops = 0; state = IDLE; holdoff counter = 0.
  - irq_req_o = 0, irq_cause_o = 0, busy_o = 0, all immediately.
- Synchronisation: each line passes SYNC_STAGES flops. A raw edge is visible SYNC_STAGES cycles later.
- Eligibility:
  - pend = {meip_s & mie_meie_i, msip_s & mie_msie_i, mtip_s & mie_mtie_i}.
  - eligible = |pend & mstatus_mie_i.
- Priority: MEI > MSI > MTI.
- Cause codes: MEI = 11, MSI = 3, MTI = 7, each with interrupt bit DATA_WIDTH-1 set.
- State machine, all transitions on posedge clk_i:
  - IDLE: if eligible and !exc_pending_i, go to ARM.
  - ARM: the winner is re-evaluated every cycle (level-sensitive, nothing latched).
    - If !eligible, go to IDLE with no request.
    - Else if instr_boundary_i & !exc_pending_i & !mret_i, go to REQ. On this edge irq_req_o <= 1 and irq_cause_o <= current winner code.
    - Otherwise stay in ARM.
  - REQ: irq_req_o and irq_cause_o are held stable.
    - The request is not withdrawn even if the line drops or the enables clear; the CSR still takes the trap.
    - exc_pending_i does not abort REQ; the CSR gives exceptions priority and acks later.
    - On irq_ack_i=1: irq_req_o <= 0, irq_cause_o <= 0, then go to HOLDOFF (load counter = HOLDOFF_CYCLES), or to IDLE directly if HOLDOFF_CYCLES = 0.
  - HOLDOFF: counter decrements each cycle; go to IDLE when it reaches 1. Eligibility is ignored in this state.
- Latency: with the line enabled, the boundary already true and exceptions idle, irq_req_o rises SYNC_STAGES+2 cycles after the raw line rises (sync, IDLE→ARM, ARM→REQ).
- irq_ack_i is ignored outside REQ. Ack in the first REQ cycle is legal; the request is then 1 cycle wide.
- A simultaneous ack and new eligible interrupt still passes through HOLDOFF.
- Reset mid-REQ: the request is dropped asynchronously and no ack is expected afterwards.

Decomposition:
- Package jedro_1_irq_pkg:
  - state enum (IDLE, ARM, REQ, HOLDOFF);
  - cause constants IRQ_CAUSE_MSI/MTI/MEI;
  - interrupt bit index;
  - holdoff counter width (4).
- Sub-module jedro_1_irq_sync: parameterised SYNC_STAGES flop chain with async active-low reset to 0; instantiated three times.

Test Plan:
1. Reset priority: ext_irq_i=1, meie=1, mstatus_mie=1, boundary=1 held at reset release → irq_req_o=1 with irq_cause_o=0x8000000B exactly 4 cycles after the line is visible to the synchroniser; ack → req=0 next cycle, busy_o low 2 cycles later.
2. Priority: sw, timer and ext all asserted with all enables set → cause 0x8000000B; after ack and holdoff, drop ext → next cause 0x80000003; drop sw → 0x80000007.
3. Masking: timer_irq_i=1, mtie=1, mstatus_mie=0 → no request for 20 cycles; set mstatus_mie=1 → request with 0x80000007.
4. Boundary/blocking: eligible, boundary=0 for 5 cycles, then boundary=1 with exc_pending_i=1, then with mret_i=1 → stays in ARM, no request; first clean boundary cycle → request next edge.
5. Withdrawal: line drops while in ARM → back to IDLE, no request; line drops while in REQ → irq_req_o stays 1 until ack.
6. Async reset during REQ (mid-cycle rstn_i low) → irq_req_o=0 and irq_cause_o=0 before the next clock edge; after release, no request until the synchroniser refills.

Source files
------------

// File: rtl/jedro_1_irq_pkg.sv
// Shared types and constants for the jedro_1 machine-mode interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jedro_1_irq_pkg;

   // Controller states: wait for work, wait for a safe boundary, hold request, settle after ack.
   typedef enum logic [1:0] {
      IDLE,
      ARM,
      REQ,
      HOLDOFF
   } irq_state_e;

   // mcause exception codes for the machine-level interrupts.
   localparam logic [3:0] IRQ_CAUSE_MSI = 4'd3;
   localparam logic [3:0] IRQ_CAUSE_MTI = 4'd7;
   localparam logic [3:0] IRQ_CAUSE_MEI = 4'd11;

   // Interrupt flag position in mcause for the native 32-bit core.
   localparam int IRQ_INT_BIT = 31;

   // Width of the post-ack holdoff counter (loads 0..15).
   localparam int HOLDOFF_CNT_W = 4;

endpackage

// File: rtl/jedro_1_irq_sync.sv
// Flop-chain synchroniser for one asynchronous interrupt line.
// Latency: SYNC_STAGES cycles from raw input to q.
// Backpressure: none; free-running sampler.
// Ports: clk_i core clock, rstn_i async active-low reset, d raw line, q synchronised line.
module jedro_1_irq_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] ff;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ff <= '0;
      end else begin
         ff[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            ff[i] <= ff[i-1];
         end
      end
   end

   assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/jedro_1_irq_ctrl.sv
// Machine-mode interrupt controller: sync, mask, prioritise, request a trap at a safe boundary.
// Latency: request rises SYNC_STAGES+2 cycles after a raw line rises (boundary open, no exception).
// Backpressure: irq_req_o/irq_cause_o held stable until irq_ack_i; then HOLDOFF_CYCLES idle cycles.
// Ports: clk_i/rstn_i clock and async active-low reset; sw/timer/ext_irq_i raw level lines;
//        mstatus_mie_i, mie_m*ie_i enables; instr_boundary_i, exc_pending_i, mret_i pipeline status;
//        irq_ack_i trap taken; irq_req_o/irq_cause_o registered request and mcause; busy_o not idle.
module jedro_1_irq_ctrl
   import jedro_1_irq_pkg::*;
#(
   parameter int DATA_WIDTH     = IRQ_INT_BIT + 1,
   parameter int SYNC_STAGES    = 2,
   parameter int HOLDOFF_CYCLES = 2
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  sw_irq_i,
   input  logic                  timer_irq_i,
   input  logic                  ext_irq_i,
   input  logic                  mstatus_mie_i,
   input  logic                  mie_msie_i,
   input  logic                  mie_mtie_i,
   input  logic                  mie_meie_i,
   input  logic                  instr_boundary_i,
   input  logic                  exc_pending_i,
   input  logic                  mret_i,
   input  logic                  irq_ack_i,
   output logic                  irq_req_o,
   output logic [DATA_WIDTH-1:0] irq_cause_o,
   output logic                  busy_o
);

   localparam logic [HOLDOFF_CNT_W-1:0] HOLDOFF_LOAD = HOLDOFF_CNT_W'(HOLDOFF_CYCLES);

   logic                     msip_s;
   logic                     mtip_s;
   logic                     meip_s;
   logic [2:0]               pend;
   logic                     eligible;
   logic [3:0]               win_code;
   logic [DATA_WIDTH-1:0]    win_cause;
   irq_state_e               state;
   logic [HOLDOFF_CNT_W-1:0] holdoff_cnt;

   jedro_1_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sw (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .d      (sw_irq_i),
      .q      (msip_s)
   );

   jedro_1_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_timer (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .d      (timer_irq_i),
      .q      (mtip_s)
   );

   jedro_1_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ext (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .d      (ext_irq_i),
      .q      (meip_s)
   );

   // Bit order {MEI, MSI, MTI} mirrors the priority order.
   assign pend     = {meip_s & mie_meie_i, msip_s & mie_msie_i, mtip_s & mie_mtie_i};
   assign eligible = (|pend) & mstatus_mie_i;

   // Later assignments override earlier ones, so the highest priority wins.
   always_comb begin
      win_code = IRQ_CAUSE_MTI;
      if (pend[1]) win_code = IRQ_CAUSE_MSI;
      if (pend[2]) win_code = IRQ_CAUSE_MEI;
   end

   always_comb begin
      win_cause                 = '0;
      win_cause[DATA_WIDTH-1]   = 1'b1;
      win_cause[3:0]            = win_code;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state       <= IDLE;
         holdoff_cnt <= '0;
         irq_req_o   <= 1'b0;
         irq_cause_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (eligible && !exc_pending_i) state <= ARM;
            end
            ARM: begin
               // Winner is taken live on the issuing edge; nothing is latched while waiting.
               if (!eligible) begin
                  state <= IDLE;
               end else if (instr_boundary_i && !exc_pending_i && !mret_i) begin
                  state       <= REQ;
                  irq_req_o   <= 1'b1;
                  irq_cause_o <= win_cause;
               end
            end
            REQ: begin
               // Committed: line drops, mask changes and exceptions cannot withdraw the request.
               if (irq_ack_i) begin
                  irq_req_o   <= 1'b0;
                  irq_cause_o <= '0;
                  holdoff_cnt <= HOLDOFF_LOAD;
                  state       <= (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
               end
            end
            HOLDOFF: begin
               // Gives the CSR's mstatus.MIE clear time to reach us before re-arbitrating.
               holdoff_cnt <= holdoff_cnt - 1'b1;
               if (holdoff_cnt <= 1) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy_o = (state != IDLE);

endmodule
